// File: rtl/fsm_lockstep_checker_if.sv
// ----------------------------------------------------------------------------
// fsm_lockstep_checker_if
//   Bundle between the FSM-equivalence harness and the lockstep checker.
//   master : harness side, drives the check window controls and lane values.
//   slave  : checker side, returns the status, sticky and counter outputs.
//
//   enable           master->slave  check window request (level)
//   clear            master->slave  synchronous clear of all checker state
//   lanes            master->slave  packed lane outputs, lane k at [k*W +: W]
//   checking         slave->master  checker is comparing this cycle
//   mismatch         slave->master  one-cycle pulse per mismatching cycle
//   fail             slave->master  sticky, set on first mismatch
//   lane_err         slave->master  sticky per-lane difference mask
//   err_count        slave->master  saturating count of mismatching cycles
//   cycle_count      slave->master  saturating count of checked cycles
//   first_fail_cycle slave->master  cycle_count at the first mismatch
// ----------------------------------------------------------------------------
interface fsm_lockstep_checker_if #(
    parameter int LANES = 4,
    parameter int W     = 2,
    parameter int CNT_W = 16
);
    logic                   enable;
    logic                   clear;
    logic [LANES*W-1:0]     lanes;
    logic                   checking;
    logic                   mismatch;
    logic                   fail;
    logic [LANES-1:0]       lane_err;
    logic [CNT_W-1:0]       err_count;
    logic [CNT_W-1:0]       cycle_count;
    logic [CNT_W-1:0]       first_fail_cycle;

    modport master (
        output enable, clear, lanes,
        input  checking, mismatch, fail, lane_err,
               err_count, cycle_count, first_fail_cycle
    );

    modport slave (
        input  enable, clear, lanes,
        output checking, mismatch, fail, lane_err,
               err_count, cycle_count, first_fail_cycle
    );
endinterface

// File: rtl/fsm_lockstep_checker.sv
// ----------------------------------------------------------------------------
// fsm_lockstep_checker
//   Compares LANES redundant copies of one FSM against lane 0 inside an
//   enabled check window. Mismatches are flagged with a one-cycle pulse,
//   recorded per lane, counted and time-stamped with the checked-cycle count.
//
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : fsm_lockstep_checker_if.slave (controls in, status out)
// ----------------------------------------------------------------------------
module fsm_lockstep_checker #(
    parameter int LANES        = 4,
    parameter int W            = 2,
    parameter int ARM_CYCLES   = 1,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fsm_lockstep_checker_if.slave  bus
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'((ARM_CYCLES > 0) ? (ARM_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Per-lane inequality against lane 0; bit 0 is structurally 0.
    function automatic logic [LANES-1:0] lane_diff(input logic [LANES*W-1:0] v);
        logic [LANES-1:0] m;
        m = {LANES{1'b0}};
        for (int k = 1; k < LANES; k++) begin
            m[k] = |(v[k*W +: W] ^ v[0 +: W]);
        end
        return m;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_W'(1'b1);
        end
    endfunction

    state_e             state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic               mismatch_q, mismatch_d;
    logic               fail_q, fail_d;
    logic [LANES-1:0]   lane_err_q, lane_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]   first_fail_q, first_fail_d;
    logic [LANES-1:0]   diff_s;

    assign diff_s = lane_diff(bus.lanes);

    // Next-state, comparison and counter update logic.
    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        mismatch_d    = 1'b0;
        fail_d        = fail_q;
        lane_err_d    = lane_err_q;
        err_count_d   = err_count_q;
        cycle_count_d = cycle_count_q;
        first_fail_d  = first_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    if (ARM_CYCLES == 0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d   = ST_ARM;
                        arm_cnt_d = ARM_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (arm_cnt_q == {ARM_W{1'b0}}) begin
                    state_d = ST_CHECK;
                end else begin
                    arm_cnt_d = arm_cnt_q - ARM_W'(1'b1);
                end
            end
            ST_CHECK: begin
                // The mismatching cycle itself is counted as a checked cycle.
                cycle_count_d = sat_inc(cycle_count_q);
                if (|diff_s) begin
                    mismatch_d  = 1'b1;
                    fail_d      = 1'b1;
                    lane_err_d  = lane_err_q | diff_s;
                    err_count_d = sat_inc(err_count_q);
                    if (!fail_q) begin
                        first_fail_d = cycle_count_q;
                    end else begin
                        first_fail_d = first_fail_q;
                    end
                end else begin
                    mismatch_d = 1'b0;
                end
                // A stopping mismatch wins over a window close on the same cycle.
                if ((|diff_s) && STOP_ON_FAIL) begin
                    state_d = ST_HALT;
                end else if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers; clear overrides every other update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            arm_cnt_q     <= {ARM_W{1'b0}};
            mismatch_q    <= 1'b0;
            fail_q        <= 1'b0;
            lane_err_q    <= {LANES{1'b0}};
            err_count_q   <= {CNT_W{1'b0}};
            cycle_count_q <= {CNT_W{1'b0}};
            first_fail_q  <= {CNT_W{1'b0}};
        end else if (bus.clear) begin
            state_q       <= ST_IDLE;
            arm_cnt_q     <= {ARM_W{1'b0}};
            mismatch_q    <= 1'b0;
            fail_q        <= 1'b0;
            lane_err_q    <= {LANES{1'b0}};
            err_count_q   <= {CNT_W{1'b0}};
            cycle_count_q <= {CNT_W{1'b0}};
            first_fail_q  <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            mismatch_q    <= mismatch_d;
            fail_q        <= fail_d;
            lane_err_q    <= lane_err_d;
            err_count_q   <= err_count_d;
            cycle_count_q <= cycle_count_d;
            first_fail_q  <= first_fail_d;
        end
    end

    assign bus.checking         = (state_q == ST_CHECK);
    assign bus.mismatch         = mismatch_q;
    assign bus.fail             = fail_q;
    assign bus.lane_err         = lane_err_q;
    assign bus.err_count        = err_count_q;
    assign bus.cycle_count      = cycle_count_q;
    assign bus.first_fail_cycle = first_fail_q;

endmodule

// File: tb/tb_fsm_lockstep_checker.sv
// ----------------------------------------------------------------------------
// tb_fsm_lockstep_checker
//   Directed bench for fsm_lockstep_checker. Three instances:
//     dut_a : defaults (ARM_CYCLES=1, STOP_ON_FAIL=1, CNT_W=16)
//     dut_b : STOP_ON_FAIL=0
//     dut_c : ARM_CYCLES=0, CNT_W=4, STOP_ON_FAIL=0
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_fsm_lockstep_checker;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    fsm_lockstep_checker_if #(.LANES(4), .W(2), .CNT_W(16)) if_a ();
    fsm_lockstep_checker_if #(.LANES(4), .W(2), .CNT_W(16)) if_b ();
    fsm_lockstep_checker_if #(.LANES(4), .W(2), .CNT_W(4))  if_c ();

    fsm_lockstep_checker #(.LANES(4), .W(2), .ARM_CYCLES(1), .CNT_W(16), .STOP_ON_FAIL(1'b1))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    fsm_lockstep_checker #(.LANES(4), .W(2), .ARM_CYCLES(1), .CNT_W(16), .STOP_ON_FAIL(1'b0))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
    fsm_lockstep_checker #(.LANES(4), .W(2), .ARM_CYCLES(0), .CNT_W(4), .STOP_ON_FAIL(1'b0))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane packing: arguments are lane3..lane0.
    function automatic logic [7:0] pk(input logic [1:0] l3, input logic [1:0] l2,
                                      input logic [1:0] l1, input logic [1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if_a.enable = 1'b0; if_a.clear = 1'b0; if_a.lanes = 8'h00;
        if_b.enable = 1'b0; if_b.clear = 1'b0; if_b.lanes = 8'h00;
        if_c.enable = 1'b0; if_c.clear = 1'b0; if_c.lanes = 8'h00;
        step();
        step();
        checks++; if (if_a.checking !== 1'b0) begin failures++; $display("FAIL reset_checking: got %0b want 0", if_a.checking); end
        checks++; if (if_a.fail !== 1'b0) begin failures++; $display("FAIL reset_fail: got %0b want 0", if_a.fail); end
        checks++; if (if_a.cycle_count !== 16'd0) begin failures++; $display("FAIL reset_cycle_count: got %0d want 0", if_a.cycle_count); end
        checks++; if (if_a.err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count: got %0d want 0", if_a.err_count); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_equal_run();
        if_a.lanes  = pk(2'd0, 2'd0, 2'd0, 2'd0);
        if_a.enable = 1'b1;
        step();  // IDLE -> ARM
        checks++; if (if_a.checking !== 1'b0) begin failures++; $display("FAIL arm_not_checking: got %0b want 0", if_a.checking); end
        step();  // ARM -> CHECK
        checks++; if (if_a.checking !== 1'b1) begin failures++; $display("FAIL enter_check: got %0b want 1", if_a.checking); end
        checks++; if (if_a.cycle_count !== 16'd0) begin failures++; $display("FAIL enter_check_count: got %0d want 0", if_a.cycle_count); end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] v;
            v = 2'(i);
            if_a.lanes = pk(v, v, v, v);
            step();
        end
        checks++; if (if_a.cycle_count !== 16'd8) begin failures++; $display("FAIL equal_cycle_count: got %0d want 8", if_a.cycle_count); end
        checks++; if (if_a.err_count !== 16'd0) begin failures++; $display("FAIL equal_err_count: got %0d want 0", if_a.err_count); end
        checks++; if (if_a.fail !== 1'b0) begin failures++; $display("FAIL equal_fail: got %0b want 0", if_a.fail); end
        checks++; if (if_a.lane_err !== 4'b0000) begin failures++; $display("FAIL equal_lane_err: got %b want 0000", if_a.lane_err); end
        checks++; if (if_a.mismatch !== 1'b0) begin failures++; $display("FAIL equal_mismatch: got %0b want 0", if_a.mismatch); end
    endtask

    task automatic test_stop_on_fail();
        if_a.enable = 1'b0;
        if_a.clear  = 1'b1;
        step();
        if_a.clear  = 1'b0;
        checks++; if (if_a.cycle_count !== 16'd0) begin failures++; $display("FAIL clear_cycle_count: got %0d want 0", if_a.cycle_count); end
        if_a.enable = 1'b1;
        if_a.lanes  = pk(2'd0, 2'd0, 2'd0, 2'd0);
        step();  // ARM
        step();  // CHECK, cycle_count 0
        for (int i = 0; i < 3; i++) begin
            step();
        end
        checks++; if (if_a.cycle_count !== 16'd3) begin failures++; $display("FAIL pre_fail_count: got %0d want 3", if_a.cycle_count); end
        if_a.lanes = pk(2'd1, 2'd2, 2'd1, 2'd1);
        step();
        checks++; if (if_a.mismatch !== 1'b1) begin failures++; $display("FAIL halt_mismatch_pulse: got %0b want 1", if_a.mismatch); end
        checks++; if (if_a.lane_err !== 4'b0100) begin failures++; $display("FAIL halt_lane_err: got %b want 0100", if_a.lane_err); end
        checks++; if (if_a.err_count !== 16'd1) begin failures++; $display("FAIL halt_err_count: got %0d want 1", if_a.err_count); end
        checks++; if (if_a.first_fail_cycle !== 16'd3) begin failures++; $display("FAIL halt_first_fail: got %0d want 3", if_a.first_fail_cycle); end
        checks++; if (if_a.checking !== 1'b0) begin failures++; $display("FAIL halt_checking: got %0b want 0", if_a.checking); end
        if_a.lanes = pk(2'd2, 2'd2, 2'd2, 2'd2);
        step();
        checks++; if (if_a.mismatch !== 1'b0) begin failures++; $display("FAIL halt_pulse_end: got %0b want 0", if_a.mismatch); end
        checks++; if (if_a.fail !== 1'b1) begin failures++; $display("FAIL halt_fail_sticky: got %0b want 1", if_a.fail); end
        checks++; if (if_a.cycle_count !== 16'd4) begin failures++; $display("FAIL halt_count_frozen: got %0d want 4", if_a.cycle_count); end
    endtask

    task automatic test_clear_priority();
        if_a.clear  = 1'b1;
        if_a.enable = 1'b1;
        step();
        if_a.clear  = 1'b0;
        checks++; if (if_a.fail !== 1'b0 || if_a.checking !== 1'b0 || if_a.mismatch !== 1'b0) begin failures++; $display("FAIL clear_flags: got fail=%0b chk=%0b mm=%0b want 0", if_a.fail, if_a.checking, if_a.mismatch); end
        checks++; if (if_a.lane_err !== 4'b0000 || if_a.err_count !== 16'd0) begin failures++; $display("FAIL clear_errs: got lane_err=%b err=%0d want 0", if_a.lane_err, if_a.err_count); end
        checks++; if (if_a.cycle_count !== 16'd0 || if_a.first_fail_cycle !== 16'd0) begin failures++; $display("FAIL clear_counts: got cyc=%0d ffc=%0d want 0", if_a.cycle_count, if_a.first_fail_cycle); end
        step();  // IDLE -> ARM
        checks++; if (if_a.checking !== 1'b0) begin failures++; $display("FAIL clear_then_arm: got %0b want 0", if_a.checking); end
        step();  // ARM -> CHECK
        checks++; if (if_a.checking !== 1'b1) begin failures++; $display("FAIL clear_then_check: got %0b want 1", if_a.checking); end
        // Mismatch on the same edge as clear must not produce a pulse.
        if_a.lanes = pk(2'd0, 2'd0, 2'd0, 2'd1);
        if_a.clear = 1'b1;
        step();
        if_a.clear = 1'b0;
        if_a.lanes = pk(2'd0, 2'd0, 2'd0, 2'd0);
        checks++; if (if_a.mismatch !== 1'b0 || if_a.fail !== 1'b0) begin failures++; $display("FAIL clear_suppress: got mm=%0b fail=%0b want 0", if_a.mismatch, if_a.fail); end
        step();  // ARM
        step();  // CHECK, cycle_count 0
    endtask

    task automatic test_reentry();
        if_a.enable = 1'b0;
        step();  // last CHECK cycle counted, then IDLE
        checks++; if (if_a.checking !== 1'b0 || if_a.cycle_count !== 16'd1) begin failures++; $display("FAIL exit_window: got chk=%0b cyc=%0d want 0/1", if_a.checking, if_a.cycle_count); end
        if_a.enable = 1'b1;
        step();  // ARM
        if_a.enable = 1'b0;
        step();  // ARM -> IDLE
        checks++; if (if_a.checking !== 1'b0 || if_a.cycle_count !== 16'd1) begin failures++; $display("FAIL arm_abort: got chk=%0b cyc=%0d want 0/1", if_a.checking, if_a.cycle_count); end
        if_a.enable = 1'b1;
        step();  // ARM
        step();  // CHECK
        checks++; if (if_a.checking !== 1'b1 || if_a.cycle_count !== 16'd1) begin failures++; $display("FAIL reentry_retain: got chk=%0b cyc=%0d want 1/1", if_a.checking, if_a.cycle_count); end
        step();
        checks++; if (if_a.cycle_count !== 16'd2) begin failures++; $display("FAIL reentry_continue: got %0d want 2", if_a.cycle_count); end
        if_a.enable = 1'b0;
        step();
    endtask

    task automatic test_no_stop();
        if_b.enable = 1'b1;
        if_b.lanes  = pk(2'd0, 2'd0, 2'd0, 2'd0);
        step();  // ARM
        step();  // CHECK, cycle_count 0
        for (int c = 0; c < 7; c++) begin
            logic [1:0] v;
            v = 2'(c);
            if (c == 2) begin
                if_b.lanes = pk(v, v, 2'd3, v);
            end else if (c == 5) begin
                if_b.lanes = pk(2'd0, v, v, v);
            end else begin
                if_b.lanes = pk(v, v, v, v);
            end
            step();
            if (c == 2) begin
                checks++; if (if_b.mismatch !== 1'b1) begin failures++; $display("FAIL nostop_pulse: got %0b want 1", if_b.mismatch); end
            end else if (c == 3) begin
                checks++; if (if_b.mismatch !== 1'b0) begin failures++; $display("FAIL nostop_pulse_end: got %0b want 0", if_b.mismatch); end
            end
        end
        checks++; if (if_b.err_count !== 16'd2) begin failures++; $display("FAIL nostop_err_count: got %0d want 2", if_b.err_count); end
        checks++; if (if_b.lane_err !== 4'b1010) begin failures++; $display("FAIL nostop_lane_err: got %b want 1010", if_b.lane_err); end
        checks++; if (if_b.first_fail_cycle !== 16'd2) begin failures++; $display("FAIL nostop_first_fail: got %0d want 2", if_b.first_fail_cycle); end
        checks++; if (if_b.checking !== 1'b1 || if_b.cycle_count !== 16'd7) begin failures++; $display("FAIL nostop_running: got chk=%0b cyc=%0d want 1/7", if_b.checking, if_b.cycle_count); end
    endtask

    task automatic test_saturation();
        if_c.enable = 1'b1;
        if_c.lanes  = pk(2'd0, 2'd0, 2'd0, 2'd0);
        step();  // IDLE -> CHECK directly (no arm phase)
        checks++; if (if_c.checking !== 1'b1 || if_c.cycle_count !== 4'd0) begin failures++; $display("FAIL noarm_direct: got chk=%0b cyc=%0d want 1/0", if_c.checking, if_c.cycle_count); end
        if_c.lanes = pk(2'd0, 2'd0, 2'd1, 2'd0);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checks++; if (if_c.err_count !== 4'd15) begin failures++; $display("FAIL sat_err_count: got %0d want 15", if_c.err_count); end
        checks++; if (if_c.cycle_count !== 4'd15) begin failures++; $display("FAIL sat_cycle_count: got %0d want 15", if_c.cycle_count); end
        checks++; if (if_c.first_fail_cycle !== 4'd0 || if_c.lane_err !== 4'b0010) begin failures++; $display("FAIL sat_first_fail: got ffc=%0d le=%b want 0/0010", if_c.first_fail_cycle, if_c.lane_err); end
        checks++; if (if_c.checking !== 1'b1 || if_c.mismatch !== 1'b1) begin failures++; $display("FAIL sat_running: got chk=%0b mm=%0b want 1/1", if_c.checking, if_c.mismatch); end
    endtask

    task automatic test_async_reset();
        checks++; if (if_b.fail !== 1'b1 || if_b.checking !== 1'b1) begin failures++; $display("FAIL pre_reset_state: got fail=%0b chk=%0b want 1/1", if_b.fail, if_b.checking); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (if_b.fail !== 1'b0 || if_b.checking !== 1'b0 || if_b.lane_err !== 4'b0000) begin failures++; $display("FAIL async_reset_flags: got fail=%0b chk=%0b le=%b want 0", if_b.fail, if_b.checking, if_b.lane_err); end
        checks++; if (if_b.err_count !== 16'd0 || if_b.cycle_count !== 16'd0 || if_b.first_fail_cycle !== 16'd0) begin failures++; $display("FAIL async_reset_counts: got err=%0d cyc=%0d ffc=%0d want 0", if_b.err_count, if_b.cycle_count, if_b.first_fail_cycle); end
        checks++; if (if_c.err_count !== 4'd0 || if_c.mismatch !== 1'b0) begin failures++; $display("FAIL async_reset_c: got err=%0d mm=%0b want 0", if_c.err_count, if_c.mismatch); end
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_equal_run();
        test_stop_on_fail();
        test_clear_priority();
        test_reentry();
        test_no_stop();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
